axi_burst_master: RTL and testbench

- Command-driven AXI4 burst master that sits directly upstream of the team's AXI4 memory slave and drives its aw/w/b/ar/r channels.
- Converts one {dir, addr, len} command into a single INCR burst.
- Write data is streamed in on a valid/ready port; read data is streamed out on a valid/ready port.
- One transaction is in flight at a time, matching the slave's single-outstanding behaviour.

---
 rtl/axi_pkg.sv | 33 +++
 rtl/axi_burst_master.sv | 260 ++++++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi_pkg
// Brief   : Shared AXI4 encodings and burst-master state type.
// Rev     : 1.0  initial release
// ============================================================================
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned BOUNDARY_4K = 4096;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5,
        ST_ERR  = 3'd6
    } mst_state_e;

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (b > a) ? b : a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_master.sv
`default_nettype none
// ============================================================================
// Module  : axi_burst_master
// Brief   : Turns one {dir, addr, len} command into a single AXI4 INCR burst.
// Rev     : 1.0  initial release
// ============================================================================
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 256,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 1,
    parameter int AXI_ID         = 0,
    parameter int ADDR_LSB       = $clog2(AXI_DATA_WIDTH/8)
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [7:0]                    cmd_len,

    input  logic [AXI_DATA_WIDTH-1:0]     wr_data,
    input  logic [AXI_DATA_WIDTH/8-1:0]   wr_strb,
    input  logic                          wr_valid,
    output logic                          wr_ready,

    output logic [AXI_DATA_WIDTH-1:0]     rd_data,
    output logic                          rd_last,
    output logic                          rd_valid,
    input  logic                          rd_ready,

    output logic                          done,
    output logic [1:0]                    done_resp,

    output logic [AXI_ADDR_WIDTH-1:0]     aw_addr,
    output logic [7:0]                    aw_len,
    output logic [2:0]                    aw_size,
    output logic [1:0]                    aw_burst,
    output logic [AXI_ID_WIDTH-1:0]       aw_id,
    output logic                          aw_valid,
    input  logic                          aw_ready,
    output logic [2:0]                    aw_prot,
    output logic [3:0]                    aw_region,
    output logic                          aw_lock,
    output logic [3:0]                    aw_cache,
    output logic [3:0]                    aw_qos,
    output logic [AXI_USER_WIDTH-1:0]     aw_user,

    output logic [AXI_DATA_WIDTH-1:0]     w_data,
    output logic [AXI_DATA_WIDTH/8-1:0]   w_strb,
    output logic                          w_last,
    output logic [AXI_USER_WIDTH-1:0]     w_user,
    output logic                          w_valid,
    input  logic                          w_ready,

    input  logic [1:0]                    b_resp,
    input  logic [AXI_ID_WIDTH-1:0]       b_id,
    input  logic [AXI_USER_WIDTH-1:0]     b_user,
    input  logic                          b_valid,
    output logic                          b_ready,

    output logic [AXI_ADDR_WIDTH-1:0]     ar_addr,
    output logic [7:0]                    ar_len,
    output logic [2:0]                    ar_size,
    output logic [1:0]                    ar_burst,
    output logic [AXI_ID_WIDTH-1:0]       ar_id,
    output logic                          ar_valid,
    input  logic                          ar_ready,
    output logic [2:0]                    ar_prot,
    output logic [3:0]                    ar_region,
    output logic                          ar_lock,
    output logic [3:0]                    ar_cache,
    output logic [3:0]                    ar_qos,
    output logic [AXI_USER_WIDTH-1:0]     ar_user,

    input  logic [AXI_DATA_WIDTH-1:0]     r_data,
    input  logic [1:0]                    r_resp,
    input  logic                          r_last,
    input  logic [AXI_ID_WIDTH-1:0]       r_id,
    input  logic [AXI_USER_WIDTH-1:0]     r_user,
    input  logic                          r_valid,
    output logic                          r_ready
);

    localparam int unsigned BEAT_BYTES = AXI_DATA_WIDTH / 8;

    mst_state_e                  r_state;
    mst_state_e                  w_state_next;
    logic [AXI_ADDR_WIDTH-1:0]   r_addr;
    logic [7:0]                  r_len;
    logic [7:0]                  r_cnt;
    logic [1:0]                  r_resp_acc;
    logic                        r_done;
    logic [1:0]                  r_done_resp;

    logic [31:0]                 w_end_offset;
    logic                        w_cross_4k;
    logic                        w_last_beat;
    logic                        w_wbeat_fire;
    logic                        w_rbeat_fire;
    logic [1:0]                  w_resp_next;
    logic                        w_unused;

    // The boundary test uses the byte address as issued by the requester.
    assign w_end_offset = 32'(cmd_addr[11:0]) + (32'(cmd_len) + 32'd1) * BEAT_BYTES;
    assign w_cross_4k   = (w_end_offset > BOUNDARY_4K);

    assign w_last_beat  = (r_cnt == r_len);
    assign w_wbeat_fire = (r_state == ST_W) && wr_valid && w_ready;
    assign w_rbeat_fire = (r_state == ST_R) && r_valid && rd_ready;
    assign w_resp_next  = resp_max(r_resp_acc, r_resp);

    assign w_unused     = ^{b_id, b_user, r_last, r_id, r_user};

    // ------------------------------------------------------------------ state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (w_cross_4k)     w_state_next = ST_ERR;
                    else if (cmd_write) w_state_next = ST_AW;
                    else                w_state_next = ST_AR;
                end
            end
            ST_AW:   if (aw_ready) w_state_next = ST_W;
            ST_W:    if (w_wbeat_fire && w_last_beat) w_state_next = ST_B;
            ST_B:    if (b_valid) w_state_next = ST_IDLE;
            ST_AR:   if (ar_ready) w_state_next = ST_R;
            ST_R:    if (w_rbeat_fire && w_last_beat) w_state_next = ST_IDLE;
            ST_ERR:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // --------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_resp_acc  <= RESP_OKAY;
            r_done      <= 1'b0;
            r_done_resp <= RESP_OKAY;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_addr     <= {cmd_addr[AXI_ADDR_WIDTH-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
                        r_len      <= cmd_len;
                        r_cnt      <= '0;
                        r_resp_acc <= RESP_OKAY;
                    end
                end
                ST_W: begin
                    if (w_wbeat_fire) r_cnt <= r_cnt + 8'd1;
                end
                ST_B: begin
                    if (b_valid) begin
                        r_done      <= 1'b1;
                        r_done_resp <= b_resp;
                    end
                end
                ST_R: begin
                    if (w_rbeat_fire) begin
                        r_cnt      <= r_cnt + 8'd1;
                        r_resp_acc <= w_resp_next;
                        if (w_last_beat) begin
                            r_done      <= 1'b1;
                            r_done_resp <= w_resp_next;
                        end
                    end
                end
                ST_ERR: begin
                    r_done      <= 1'b1;
                    r_done_resp <= RESP_SLVERR;
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        cmd_ready = 1'b0;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        wr_ready  = 1'b0;
        w_last    = 1'b0;
        b_ready   = 1'b0;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;
        rd_valid  = 1'b0;
        rd_last   = 1'b0;
        case (r_state)
            ST_IDLE: cmd_ready = 1'b1;
            ST_AW:   aw_valid  = 1'b1;
            ST_W: begin
                w_valid  = wr_valid;
                wr_ready = w_ready;
                w_last   = w_last_beat;
            end
            ST_B:    b_ready   = 1'b1;
            ST_AR:   ar_valid  = 1'b1;
            ST_R: begin
                r_ready  = rd_ready;
                rd_valid = r_valid;
                rd_last  = w_last_beat;
            end
            default: ;
        endcase
    end

    assign done      = r_done;
    assign done_resp = r_done_resp;

    assign w_data    = wr_data;
    assign w_strb    = wr_strb;
    assign w_user    = '0;
    assign rd_data   = r_data;

    assign aw_addr   = r_addr;
    assign aw_len    = r_len;
    assign aw_size   = 3'(ADDR_LSB);
    assign aw_burst  = BURST_INCR;
    assign aw_id     = AXI_ID_WIDTH'(AXI_ID);
    assign aw_prot   = '0;
    assign aw_region = '0;
    assign aw_lock   = 1'b0;
    assign aw_cache  = '0;
    assign aw_qos    = '0;
    assign aw_user   = '0;

    assign ar_addr   = r_addr;
    assign ar_len    = r_len;
    assign ar_size   = 3'(ADDR_LSB);
    assign ar_burst  = BURST_INCR;
    assign ar_id     = AXI_ID_WIDTH'(AXI_ID);
    assign ar_prot   = '0;
    assign ar_region = '0;
    assign ar_lock   = 1'b0;
    assign ar_cache  = '0;
    assign ar_qos    = '0;
    assign ar_user   = '0;

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_burst_master
// Brief   : Directed bench for axi_burst_master with a small AXI slave model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_axi_burst_master;

    logic           clk;
    logic           rst_n;
    logic           cmd_valid, cmd_ready, cmd_write;
    logic [63:0]    cmd_addr;
    logic [7:0]     cmd_len;
    logic [255:0]   wr_data;
    logic [31:0]    wr_strb;
    logic           wr_valid, wr_ready;
    logic [255:0]   rd_data;
    logic           rd_last, rd_valid, rd_ready;
    logic           done;
    logic [1:0]     done_resp;
    logic [63:0]    aw_addr, ar_addr;
    logic [7:0]     aw_len, ar_len;
    logic [2:0]     aw_size, ar_size, aw_prot, ar_prot;
    logic [1:0]     aw_burst, ar_burst;
    logic [3:0]     aw_id, ar_id, aw_region, ar_region, aw_cache, ar_cache, aw_qos, ar_qos;
    logic           aw_valid, aw_ready, ar_valid, ar_ready, aw_lock, ar_lock;
    logic [0:0]     aw_user, ar_user, w_user, b_user, r_user;
    logic [255:0]   w_data, r_data;
    logic [31:0]    w_strb;
    logic           w_last, w_valid, w_ready;
    logic [1:0]     b_resp, r_resp;
    logic [3:0]     b_id, r_id;
    logic           b_valid, b_ready;
    logic           r_last, r_valid, r_ready;

    axi_burst_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .done_resp(done_resp),
        .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .aw_id(aw_id), .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_prot(aw_prot),
        .aw_region(aw_region), .aw_lock(aw_lock), .aw_cache(aw_cache), .aw_qos(aw_qos),
        .aw_user(aw_user),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_user(w_user),
        .w_valid(w_valid), .w_ready(w_ready),
        .b_resp(b_resp), .b_id(b_id), .b_user(b_user), .b_valid(b_valid), .b_ready(b_ready),
        .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .ar_id(ar_id), .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_prot(ar_prot),
        .ar_region(ar_region), .ar_lock(ar_lock), .ar_cache(ar_cache), .ar_qos(ar_qos),
        .ar_user(ar_user),
        .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_id(r_id), .r_user(r_user),
        .r_valid(r_valid), .r_ready(r_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: address ready one cycle after valid, w_ready always high.
    logic [255:0] mem [0:255];
    logic [7:0]   s_widx, s_ridx, s_rbeat;
    logic [8:0]   s_rleft;
    int           err_beat;

    assign w_ready = 1'b1;
    assign b_resp  = 2'b00;
    assign b_id    = '0;
    assign b_user  = '0;
    assign r_id    = '0;
    assign r_user  = '0;
    assign r_valid = (s_rleft != 9'd0);
    assign r_last  = (s_rleft == 9'd1);
    assign r_data  = mem[s_ridx];
    assign r_resp  = (int'(s_rbeat) == err_beat) ? 2'b10 : 2'b00;

    always @(posedge clk) begin
        if (!rst_n) begin
            aw_ready <= 1'b0;
            ar_ready <= 1'b0;
            b_valid  <= 1'b0;
            s_widx   <= '0;
            s_ridx   <= '0;
            s_rbeat  <= '0;
            s_rleft  <= '0;
        end else begin
            aw_ready <= aw_valid && !aw_ready;
            ar_ready <= ar_valid && !ar_ready;
            if (aw_valid && aw_ready) s_widx <= aw_addr[12:5];
            if (w_valid && w_ready) begin
                mem[s_widx] <= w_data;
                s_widx      <= s_widx + 8'd1;
                if (w_last) b_valid <= 1'b1;
            end
            if (b_valid && b_ready) b_valid <= 1'b0;
            if (ar_valid && ar_ready) begin
                s_ridx  <= ar_addr[12:5];
                s_rleft <= 9'(ar_len) + 9'd1;
                s_rbeat <= '0;
            end
            if (r_valid && r_ready) begin
                s_ridx  <= s_ridx + 8'd1;
                s_rleft <= s_rleft - 9'd1;
                s_rbeat <= s_rbeat + 8'd1;
            end
        end
    end

    int passed = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [255:0] pat(input logic [31:0] seed, input int k);
        return {8{seed + 32'(k)}};
    endfunction

    int          aw_seen, ar_seen, beats, done_cnt, done_cyc;
    logic [63:0] aw_addr_s, ar_addr_s;
    logic [7:0]  aw_len_s, ar_len_s;
    logic [2:0]  aw_size_s;
    logic [1:0]  aw_burst_s, done_resp_s;
    logic [3:0]  aw_id_s;
    logic        saw_wr_ready, early_w, aw_done;

    task automatic run_cmd(input logic wr, input logic [63:0] addr, input logic [7:0] len,
                           input logic [31:0] seed, input logic tog, input int abort_beat);
        aw_seen = 0; ar_seen = 0; beats = 0; done_cnt = 0; done_cyc = -1;
        saw_wr_ready = 1'b0; early_w = 1'b0; aw_done = 1'b0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        wr_valid = 1'b0; rd_ready = 1'b0;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            wr_data  = pat(seed, beats);
            wr_valid = wr;
            rd_ready = tog ? cyc[0] : 1'b1;
            if (abort_beat >= 0 && beats == abort_beat) begin
                rst_n = 1'b0;
                #1;
                return;
            end
            #1;
            if (cyc == 1) chk("cmd_ready_busy", cmd_ready, 1'b0);
            if (aw_valid) begin
                aw_seen++;
                aw_addr_s = aw_addr; aw_len_s = aw_len; aw_size_s = aw_size;
                aw_burst_s = aw_burst; aw_id_s = aw_id;
                if (aw_ready) aw_done = 1'b1;
            end
            if (w_valid && !aw_done) early_w = 1'b1;
            if (ar_valid) begin
                ar_seen++;
                ar_addr_s = ar_addr; ar_len_s = ar_len;
            end
            if (wr_ready) saw_wr_ready = 1'b1;
            if (w_valid && w_ready) begin
                chk("w_data", w_data, pat(seed, beats));
                chk("w_last", w_last, (beats == int'(len)));
                beats++;
            end
            if (rd_valid && rd_ready) begin
                chk("rd_data", rd_data, pat(seed, beats));
                chk("rd_last", rd_last, (beats == int'(len)));
                beats++;
            end
            if (done) begin
                done_cnt++;
                done_resp_s = done_resp;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        if (done_cyc < 0) chk("done_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_strb = '1; wr_valid = 1'b0; rd_ready = 1'b0; err_beat = -1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_valids", {aw_valid, w_valid, ar_valid, b_ready, r_ready, wr_ready, rd_valid, done}, 8'h00);
        chk("rst_done_resp", done_resp, 2'b00);
        chk("rst_aw_addr", aw_addr, 64'h0);
        chk("rst_aw_len", aw_len, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Aligned 4-beat write
        run_cmd(1'b1, 64'h40, 8'd3, 32'h1111_0000, 1'b0, -1);
        chk("wr1_aw_addr", aw_addr_s, 64'h40);
        chk("wr1_aw_len", aw_len_s, 8'd3);
        chk("wr1_aw_size", aw_size_s, 3'd5);
        chk("wr1_aw_burst", aw_burst_s, 2'b01);
        chk("wr1_aw_id", aw_id_s, 4'd0);
        chk("wr1_aw_held", aw_seen, 2);
        chk("wr1_early_w", early_w, 1'b0);
        chk("wr1_beats", beats, 4);
        chk("wr1_done_cnt", done_cnt, 1);
        chk("wr1_done_resp", done_resp_s, 2'b00);
        chk("wr1_no_ar", ar_seen, 0);
        for (int k = 0; k < 4; k++) chk("wr1_mem", mem[2 + k], pat(32'h1111_0000, k));

        // Read back with rd_ready toggling
        run_cmd(1'b0, 64'h40, 8'd3, 32'h1111_0000, 1'b1, -1);
        chk("rd1_ar_addr", ar_addr_s, 64'h40);
        chk("rd1_ar_len", ar_len_s, 8'd3);
        chk("rd1_beats", beats, 4);
        chk("rd1_done_cnt", done_cnt, 1);
        chk("rd1_done_resp", done_resp_s, 2'b00);
        chk("rd1_no_aw", aw_seen, 0);

        // Unaligned single-beat write
        run_cmd(1'b1, 64'h1F1F, 8'd0, 32'h2222_0000, 1'b0, -1);
        chk("wr2_aw_addr", aw_addr_s, 64'h1F00);
        chk("wr2_aw_len", aw_len_s, 8'd0);
        chk("wr2_beats", beats, 1);
        chk("wr2_done_cnt", done_cnt, 1);
        chk("wr2_mem", mem[8'hF8], pat(32'h2222_0000, 0));

        // 4KB crossing write command
        run_cmd(1'b1, 64'hFE0, 8'd1, 32'h3333_0000, 1'b0, -1);
        chk("err_no_aw", aw_seen, 0);
        chk("err_no_ar", ar_seen, 0);
        chk("err_no_wr_ready", saw_wr_ready, 1'b0);
        chk("err_beats", beats, 0);
        chk("err_done_cyc", done_cyc, 2);
        chk("err_done_cnt", done_cnt, 1);
        chk("err_done_resp", done_resp_s, 2'b10);

        // Reset during beat 2 of an 8-beat write
        run_cmd(1'b1, 64'h400, 8'd7, 32'h4444_0000, 1'b0, 2);
        chk("abort_valids", {aw_valid, w_valid, ar_valid, b_ready, r_ready, wr_ready, rd_valid, done}, 8'h00);
        chk("abort_cmd_ready", cmd_ready, 1'b1);
        chk("abort_aw_len", aw_len, 8'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("abort_no_done", done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_no_done_after", done, 1'b0);
        @(negedge clk);

        // Normal read after the aborted write
        run_cmd(1'b0, 64'h1F00, 8'd0, 32'h2222_0000, 1'b0, -1);
        chk("rd2_beats", beats, 1);
        chk("rd2_done_cnt", done_cnt, 1);
        chk("rd2_done_resp", done_resp_s, 2'b00);

        // Slave error on beat 1 of a 3-beat read
        err_beat = 1;
        run_cmd(1'b0, 64'h40, 8'd2, 32'h1111_0000, 1'b0, -1);
        err_beat = -1;
        chk("rd3_beats", beats, 3);
        chk("rd3_done_cnt", done_cnt, 1);
        chk("rd3_done_resp", done_resp_s, 2'b10);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
